// File: rtl/channel_pack_pkg.sv
// Shared definitions for the channel readout packer: word tags, FSM encoding
// and the tagged-word builder.
package channel_pack_pkg;

    localparam logic [3:0] TAG_HDR0  = 4'hA;
    localparam logic [3:0] TAG_HDR1  = 4'h5;
    localparam logic [3:0] TAG_DATA  = 4'h0;
    localparam logic [3:0] TAG_TRAIL = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        WAIT  = 3'd3,
        DATA  = 3'd4,
        TRAIL = 3'd5,
        DONE  = 3'd6
    } pack_state_e;

    function automatic logic [15:0] pack_word(input logic [3:0] tag, input logic [11:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/pack_fifo.sv
// First-word-fall-through 16-bit FIFO; a push while full is accepted when a
// pop frees the slot in the same cycle.
module pack_fifo #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] pop_data,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [15:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  do_pop_s;
    logic                  do_push_s;

    assign do_pop_s  = pop & ~empty_r;
    assign do_push_s = push & (~full_r | do_pop_s);

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_DEPTH);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    // The head word is forced to zero while empty so the link sees a quiet bus.
    assign pop_data = empty_r ? 16'h0000 : mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/channel_readout_packer.sv
// Reads one digitizer channel window and packs header/samples/trailer words
// into a FIFO for a valid/ready link. PACK_CHECKSUM_EN selects a checksum trailer.
module channel_readout_packer
    import channel_pack_pkg::*;
#(
    parameter int SIZE            = 12,
    parameter int WIDTH           = 12,
    parameter int START_LAT       = 2,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [SIZE-1:0]  how_many_i,
    input  logic [SIZE-1:0]  offset_i,
    output logic [SIZE-1:0]  how_many,
    output logic [SIZE-1:0]  offset,
    output logic             read_request,
    input  logic [WIDTH-1:0] data_in,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [SIZE-1:0] CNT_ONE  = SIZE'(1);
    localparam logic [SIZE-1:0] CNT_ZERO = SIZE'(0);
    localparam logic [7:0]      LAT_END  = 8'(START_LAT - 2);

    pack_state_e     state_r;
    pack_state_e     state_nxt_s;
    logic [SIZE-1:0] how_many_r;
    logic [SIZE-1:0] offset_r;
    logic [SIZE-1:0] cnt_r;
    logic [7:0]      lat_cnt_r;
    logic            overflow_r;
    logic            busy_r;
    logic            done_r;
    logic            accept_s;
    logic            can_write_s;
    logic            push_s;
    logic            drop_s;
    logic            read_request_s;
    logic [15:0]     push_data_s;
    logic [15:0]     trailer_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;

    assign accept_s = (state_r == IDLE) & start;
    // When full the head is valid, so out_ready alone means a slot frees this cycle.
    assign can_write_s = ~fifo_full_s | out_ready;

`ifdef PACK_CHECKSUM_EN
    logic [11:0] checksum_r;

    // Running mod-4096 sum of every received sample, dropped or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_r <= 12'h000;
        end else if (accept_s) begin
            checksum_r <= 12'h000;
        end else if (state_r == DATA) begin
            checksum_r <= checksum_r + 12'(data_in);
        end
    end

    assign trailer_s = pack_word(TAG_TRAIL, checksum_r);
`else
    assign trailer_s = pack_word(TAG_TRAIL, 12'(cnt_r));
`endif

    // Next-state, FIFO write and channel request decode.
    always_comb begin
        state_nxt_s    = state_r;
        push_s         = 1'b0;
        drop_s         = 1'b0;
        read_request_s = 1'b0;
        push_data_s    = 16'h0000;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = HDR0;
                else       state_nxt_s = IDLE;
            end
            HDR0: begin
                push_data_s = pack_word(TAG_HDR0, 12'(how_many_r));
                if (can_write_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = HDR1;
                end else begin
                    state_nxt_s = HDR0;
                end
            end
            HDR1: begin
                push_data_s = pack_word(TAG_HDR1, 12'(offset_r));
                if (can_write_s) begin
                    push_s = 1'b1;
                    if (how_many_r != CNT_ZERO) begin
                        read_request_s = 1'b1;
                        state_nxt_s    = (START_LAT == 1) ? DATA : WAIT;
                    end else begin
                        state_nxt_s = TRAIL;
                    end
                end else begin
                    state_nxt_s = HDR1;
                end
            end
            WAIT: begin
                if (lat_cnt_r == LAT_END) state_nxt_s = DATA;
                else                      state_nxt_s = WAIT;
            end
            DATA: begin
                push_data_s = pack_word(TAG_DATA, 12'(data_in));
                if (can_write_s) push_s = 1'b1;
                else             drop_s = 1'b1;
                if (cnt_r + CNT_ONE == how_many_r) state_nxt_s = TRAIL;
                else                               state_nxt_s = DATA;
            end
            TRAIL: begin
                push_data_s = trailer_s;
                if (can_write_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = TRAIL;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Command latch; held until the next accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            how_many_r <= CNT_ZERO;
            offset_r   <= CNT_ZERO;
        end else if (accept_s) begin
            how_many_r <= how_many_i;
            offset_r   <= offset_i;
        end
    end

    // Sample counter, start-latency counter and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= CNT_ZERO;
            lat_cnt_r  <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            lat_cnt_r <= (state_r == WAIT) ? lat_cnt_r + 8'd1 : 8'd0;
            if (accept_s) begin
                cnt_r      <= CNT_ZERO;
                overflow_r <= 1'b0;
            end else begin
                if (state_r == DATA) cnt_r <= cnt_r + CNT_ONE;
                if (drop_s)          overflow_r <= 1'b1;
            end
        end
    end

    pack_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign out_valid    = ~fifo_empty_s;
    assign read_request = read_request_s;
    assign how_many     = how_many_r;
    assign offset       = offset_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_channel_readout_packer.sv
// Directed bench for channel_readout_packer: a 32-deep instance for the main
// packets and a 4-deep instance for sample-drop behaviour.
module tb_channel_readout_packer;

    localparam int START_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] how_many_i = 12'h000;
    logic [11:0] offset_i = 12'h000;
    logic [11:0] data_in = 12'hEEE;

    logic        start_a = 1'b0, ready_man_a = 1'b1, rand_ready = 1'b0, rnd_r = 1'b1;
    logic        ready_a;
    logic [11:0] how_many_a, offset_a;
    logic [15:0] out_data_a;
    logic        read_request_a, out_valid_a, busy_a, done_a, overflow_a;

    logic        start_b = 1'b0, ready_b = 1'b0;
    logic [11:0] how_many_b, offset_b;
    logic [15:0] out_data_b;
    logic        read_request_b, out_valid_b, busy_b, done_b, overflow_b;

    assign ready_a = rand_ready ? rnd_r : ready_man_a;

    channel_readout_packer #(.SIZE(12), .WIDTH(12), .START_LAT(START_LAT), .FIFO_DEPTH_LOG2(5)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .how_many_i(how_many_i), .offset_i(offset_i),
        .how_many(how_many_a), .offset(offset_a), .read_request(read_request_a), .data_in(data_in),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(ready_a), .busy(busy_a),
        .done(done_a), .overflow(overflow_a));

    channel_readout_packer #(.SIZE(12), .WIDTH(12), .START_LAT(START_LAT), .FIFO_DEPTH_LOG2(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .how_many_i(how_many_i), .offset_i(offset_i),
        .how_many(how_many_b), .offset(offset_b), .read_request(read_request_b), .data_in(data_in),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(ready_b), .busy(busy_b),
        .done(done_b), .overflow(overflow_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0]         hm;
        logic [11:0]         off;
        logic [0:3][11:0]    samp;
        logic [3:0]          nw;
        logic [0:5][15:0]    words;
        logic [15:0]         trl_cnt;
        logic [15:0]         trl_sum;
    } vec_t;

    vec_t        vecs [4];
    logic [11:0] chan_samp [8];
    int          chan_n = 0;
    int          cyc = 0;
    int          rr_cyc = -100;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rr_cnt_a = 0, done_cnt_a = 0, rr_cnt_b = 0, done_cnt_b = 0;
    logic [15:0] words_a [$];
    logic [15:0] words_b [$];

    // Channel model: samples appear START_LAT clocks after the request cycle.
    always begin
        int idx;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        idx = cyc - rr_cyc - START_LAT;
        if (idx >= 0 && idx < chan_n) data_in = chan_samp[idx];
        else                          data_in = 12'hEEE;
        rnd_r = 1'($urandom_range(0, 1));
    end

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (read_request_a) begin rr_cnt_a++; rr_cyc = cyc; end
        if (read_request_b) begin rr_cnt_b++; rr_cyc = cyc; end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (out_valid_a && ready_a) words_a.push_back(out_data_a);
        if (out_valid_b && ready_b) words_b.push_back(out_data_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_trl(input vec_t v);
`ifdef PACK_CHECKSUM_EN
        return v.trl_sum;
`else
        return v.trl_cnt;
`endif
    endfunction

    task automatic run_a(input vec_t v, input bit randrdy, input bit nag, input string tag);
        int wb, db, rb, total;
        for (int i = 0; i < 4; i++) chan_samp[i] = v.samp[i];
        chan_n = int'(v.hm);
        wb = words_a.size(); db = done_cnt_a; rb = rr_cnt_a;
        total = int'(v.nw) + 1;
        rand_ready = randrdy;
        ready_man_a = 1'b1;
        @(posedge clk); #1;
        how_many_i = v.hm; offset_i = v.off; start_a = 1'b1;
        @(posedge clk); #1;
        if (nag) begin
            how_many_i = 12'h007; offset_i = 12'h123;
            repeat (5) @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        for (int c = 0; c < 400 && (words_a.size() < wb + total || done_cnt_a == db); c++)
            @(posedge clk);
        repeat (6) @(posedge clk);
        rand_ready = 1'b0;
        #2;
        check({tag, " word_count"}, 32'(words_a.size() - wb), 32'(total));
        for (int i = 0; i < int'(v.nw); i++)
            check($sformatf("%s word%0d", tag, i),
                  (wb + i < words_a.size()) ? 32'(words_a[wb + i]) : 32'hDEAD, 32'(v.words[i]));
        check({tag, " trailer"},
              (wb + total - 1 < words_a.size()) ? 32'(words_a[wb + total - 1]) : 32'hDEAD, 32'(exp_trl(v)));
        check({tag, " done_pulses"}, 32'(done_cnt_a - db), 32'd1);
        check({tag, " read_requests"}, 32'(rr_cnt_a - rb), (v.hm != 12'h000) ? 32'd1 : 32'd0);
        check({tag, " overflow"}, 32'(overflow_a), 32'd0);
        check({tag, " busy_after"}, 32'(busy_a), 32'd0);
        check({tag, " how_many_out"}, 32'(how_many_a), 32'(v.hm));
        check({tag, " offset_out"}, 32'(offset_a), 32'(v.off));
    endtask

    initial begin
        int wb, db;
        vecs[0] = '{hm: 12'd4, off: 12'h010, samp: {12'h001, 12'h002, 12'h003, 12'h004}, nw: 4'd6,
                    words: {16'hA004, 16'h5010, 16'h0001, 16'h0002, 16'h0003, 16'h0004},
                    trl_cnt: 16'hF004, trl_sum: 16'hF00A};
        vecs[1] = '{hm: 12'd0, off: 12'h000, samp: {12'h000, 12'h000, 12'h000, 12'h000}, nw: 4'd2,
                    words: {16'hA000, 16'h5000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    trl_cnt: 16'hF000, trl_sum: 16'hF000};
        vecs[2] = '{hm: 12'd3, off: 12'hABC, samp: {12'hFFF, 12'h800, 12'h001, 12'h000}, nw: 4'd5,
                    words: {16'hA003, 16'h5ABC, 16'h0FFF, 16'h0800, 16'h0001, 16'h0000},
                    trl_cnt: 16'hF003, trl_sum: 16'hF800};
        vecs[3] = '{hm: 12'd1, off: 12'hFFF, samp: {12'h5A5, 12'h000, 12'h000, 12'h000}, nw: 4'd3,
                    words: {16'hA001, 16'h5FFF, 16'h05A5, 16'h0000, 16'h0000, 16'h0000},
                    trl_cnt: 16'hF001, trl_sum: 16'hF5A5};

        repeat (3) @(posedge clk);
        #2;
        check("rst out_valid", 32'(out_valid_a), 32'd0);
        check("rst out_data", 32'(out_data_a), 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst done", 32'(done_a), 32'd0);
        check("rst overflow", 32'(overflow_a), 32'd0);
        check("rst read_request", 32'(read_request_a), 32'd0);
        check("rst how_many", 32'(how_many_a), 32'd0);
        check("rst offset", 32'(offset_a), 32'd0);
        check("rst b out_valid", 32'(out_valid_b), 32'd0);
        reset_n = 1'b1;

        for (int k = 0; k < 4; k++) run_a(vecs[k], 1'b0, 1'b0, $sformatf("vec%0d", k));

        run_a(vecs[0], 1'b0, 1'b1, "busy_start");
        run_a(vecs[2], 1'b1, 1'b0, "backpressure");

        // Overflow on the 4-deep instance: two headers plus two samples fill it.
        for (int i = 0; i < 8; i++) chan_samp[i] = 12'(i + 1);
        chan_n = 8;
        wb = words_b.size(); db = done_cnt_b;
        ready_b = 1'b0;
        @(posedge clk); #1;
        how_many_i = 12'd8; offset_i = 12'h000; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        check("ovf overflow_set", 32'(overflow_b), 32'd1);
        check("ovf busy_stalled", 32'(busy_b), 32'd1);
        check("ovf no_done_yet", 32'(done_cnt_b - db), 32'd0);
        check("ovf head_word", 32'(out_data_b), 32'hA008);
        ready_b = 1'b1;
        for (int c = 0; c < 200 && done_cnt_b == db; c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        check("ovf word_count", 32'(words_b.size() - wb), 32'd5);
        check("ovf w0", (wb < words_b.size()) ? 32'(words_b[wb]) : 32'hDEAD, 32'hA008);
        check("ovf w1", (wb + 1 < words_b.size()) ? 32'(words_b[wb + 1]) : 32'hDEAD, 32'h5000);
        check("ovf w2", (wb + 2 < words_b.size()) ? 32'(words_b[wb + 2]) : 32'hDEAD, 32'h0001);
        check("ovf w3", (wb + 3 < words_b.size()) ? 32'(words_b[wb + 3]) : 32'hDEAD, 32'h0002);
`ifdef PACK_CHECKSUM_EN
        check("ovf trailer", (wb + 4 < words_b.size()) ? 32'(words_b[wb + 4]) : 32'hDEAD, 32'hF024);
`else
        check("ovf trailer", (wb + 4 < words_b.size()) ? 32'(words_b[wb + 4]) : 32'hDEAD, 32'hF008);
`endif
        check("ovf done_pulses", 32'(done_cnt_b - db), 32'd1);
        check("ovf sticky", 32'(overflow_b), 32'd1);

        // A new accepted start clears the sticky flag.
        wb = words_b.size();
        @(posedge clk); #1;
        how_many_i = 12'd0; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        #1;
        check("ovf cleared", 32'(overflow_b), 32'd0);
        repeat (10) @(posedge clk);
        #2;
        check("ovf2 word_count", 32'(words_b.size() - wb), 32'd3);
        check("ovf2 trailer", (wb + 2 < words_b.size()) ? 32'(words_b[wb + 2]) : 32'hDEAD, 32'hF000);

        // Asynchronous reset in the middle of DATA.
        for (int i = 0; i < 8; i++) chan_samp[i] = 12'(16 * i + 3);
        chan_n = 8;
        ready_man_a = 1'b0;
        db = rr_cnt_a;
        @(posedge clk); #1;
        how_many_i = 12'd8; offset_i = 12'h044; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int c = 0; c < 50 && rr_cnt_a == db; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst busy", 32'(busy_a), 32'd1);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid out_valid", 32'(out_valid_a), 32'd0);
        check("rst_mid busy", 32'(busy_a), 32'd0);
        check("rst_mid read_request", 32'(read_request_a), 32'd0);
        check("rst_mid how_many", 32'(how_many_a), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_a(vecs[0], 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
